sync_width_fifo: RTL and testbench

Single-clock FIFO with parametrised write/read width conversion (wide-to-narrow or narrow-to-wide, power-of-two ratio), programmable almost-full/almost-empty thresholds, water levels on both sides, flush, and overflow/underflow pulses. It is the same-clock successor to the 16-to-8 cache-to-frame buffers. It sits between the audio/data cache path and frame packers where producer and consumer share one clock but differ in word width.

---
 rtl/sync_width_fifo_pkg.sv | 60 ++++++
 rtl/sync_width_fifo_ram.sv | 30 +++
 rtl/sync_width_fifo.sv | 165 ++++++++++++++++
 tb/tb_sync_width_fifo.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sync_width_fifo_pkg.sv
// Shared derivations for sync_width_fifo: width ratio, unit sizes, capacity and level width.
// All values are computed from the top-level parameters at elaboration time.
package sync_width_fifo_pkg;

  typedef enum logic [1:0] {
    MODE_EQUAL,
    MODE_WIDE_TO_NARROW,
    MODE_NARROW_TO_WIDE
  } width_mode_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic int narrow_width(input int wr_w, input int rd_w);
    return (wr_w < rd_w) ? wr_w : rd_w;
  endfunction

  function automatic int wide_width(input int wr_w, input int rd_w);
    return (wr_w > rd_w) ? wr_w : rd_w;
  endfunction

  function automatic int ratio(input int wr_w, input int rd_w);
    return wide_width(wr_w, rd_w) / narrow_width(wr_w, rd_w);
  endfunction

  function automatic bit ratio_legal(input int wr_w, input int rd_w);
    int r;
    r = ratio(wr_w, rd_w);
    return (r == 1 || r == 2 || r == 4 || r == 8) &&
           (narrow_width(wr_w, rd_w) * r == wide_width(wr_w, rd_w));
  endfunction

  // Occupancy is counted in narrow units; these give the step per accepted word.
  function automatic int write_units(input int wr_w, input int rd_w);
    return (wr_w > rd_w) ? ratio(wr_w, rd_w) : 1;
  endfunction

  function automatic int read_units(input int wr_w, input int rd_w);
    return (rd_w > wr_w) ? ratio(wr_w, rd_w) : 1;
  endfunction

  function automatic int capacity(input int depth_w, input int wr_w, input int rd_w);
    return ratio(wr_w, rd_w) << depth_w;
  endfunction

  function automatic int level_width(input int depth_w, input int wr_w, input int rd_w);
    return depth_w + clog2(ratio(wr_w, rd_w)) + 1;
  endfunction

  function automatic width_mode_e width_mode(input int wr_w, input int rd_w);
    if (wr_w > rd_w) return MODE_WIDE_TO_NARROW;
    if (rd_w > wr_w) return MODE_NARROW_TO_WIDE;
    return MODE_EQUAL;
  endfunction

endpackage

// File: rtl/sync_width_fifo_ram.sv
// Simple dual-port memory of wide words: synchronous write, registered read with clear.
module sync_width_fifo_ram #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(1 << ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (clr_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_width_fifo.sv
// Single-clock FIFO with power-of-two width conversion; occupancy is one counter in narrow units
// and every flag and level is decoded from it.
module sync_width_fifo
  import sync_width_fifo_pkg::*;
#(
  parameter int WR_DATA_WIDTH    = 16,
  parameter int RD_DATA_WIDTH    = 8,
  parameter int DEPTH_WIDTH      = 9,
  parameter int MSB_FIRST        = 0,
  parameter int ALMOST_FULL_NUM  = 120,
  parameter int ALMOST_EMPTY_NUM = 4,
  localparam int LVL_W = level_width(DEPTH_WIDTH, WR_DATA_WIDTH, RD_DATA_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WR_DATA_WIDTH-1:0] wr_data,
  output logic                     wr_full,
  output logic                     almost_full,
  output logic [LVL_W-1:0]         wr_water_level,
  input  logic                     rd_en,
  output logic [RD_DATA_WIDTH-1:0] rd_data,
  output logic                     rd_empty,
  output logic                     almost_empty,
  output logic [LVL_W-1:0]         rd_water_level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int R     = ratio(WR_DATA_WIDTH, RD_DATA_WIDTH);
  localparam int NW    = narrow_width(WR_DATA_WIDTH, RD_DATA_WIDTH);
  localparam int WW    = wide_width(WR_DATA_WIDTH, RD_DATA_WIDTH);
  localparam int WU    = write_units(WR_DATA_WIDTH, RD_DATA_WIDTH);
  localparam int RU    = read_units(WR_DATA_WIDTH, RD_DATA_WIDTH);
  localparam int C     = capacity(DEPTH_WIDTH, WR_DATA_WIDTH, RD_DATA_WIDTH);
  localparam int WU_SH = clog2(WU);
  localparam int RU_SH = clog2(RU);
  localparam int SUB_W = (R > 1) ? clog2(R) : 1;
  localparam width_mode_e MODE = width_mode(WR_DATA_WIDTH, RD_DATA_WIDTH);
  localparam logic [LVL_W-1:0] WU_L = LVL_W'(WU);
  localparam logic [LVL_W-1:0] RU_L = LVL_W'(RU);
  localparam logic [LVL_W-1:0] C_L  = LVL_W'(C);

  if (!ratio_legal(WR_DATA_WIDTH, RD_DATA_WIDTH)) begin : g_bad_ratio
    $error("sync_width_fifo: wide width must be the narrow width times 1, 2, 4 or 8");
  end

  logic                   hold;
  logic                   wr_accept, rd_accept;
  logic                   wr_ptr_adv, rd_ptr_adv;
  logic [LVL_W-1:0]       lvl_q, lvl_d;
  logic [DEPTH_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic                   overflow_q, underflow_q;
  logic                   ram_we;
  logic [WW-1:0]          ram_wdata, ram_rdata;

  assign hold      = rst | flush;
  assign wr_accept = wr_en & ~wr_full & ~hold;
  assign rd_accept = rd_en & ~rd_empty & ~hold;

  assign wr_full        = (C_L - lvl_q) < WU_L;
  assign rd_empty       = lvl_q < RU_L;
  assign wr_water_level = lvl_q >> WU_SH;
  assign rd_water_level = lvl_q >> RU_SH;
  // Thresholds are compared as int so a value beyond the level range simply never trips.
  assign almost_full    = int'(wr_water_level) >= ALMOST_FULL_NUM;
  assign almost_empty   = int'(rd_water_level) <= ALMOST_EMPTY_NUM;
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;

  always_comb begin
    lvl_d = lvl_q;
    if (wr_accept) lvl_d = lvl_d + WU_L;
    if (rd_accept) lvl_d = lvl_d - RU_L;
  end

  always_ff @(posedge clk) begin
    if (hold) begin
      lvl_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      lvl_q       <= lvl_d;
      overflow_q  <= wr_en & wr_full;
      underflow_q <= rd_en & rd_empty;
      if (wr_ptr_adv) wr_ptr_q <= wr_ptr_q + DEPTH_WIDTH'(1);
      if (rd_ptr_adv) rd_ptr_q <= rd_ptr_q + DEPTH_WIDTH'(1);
    end
  end

  if (MODE == MODE_NARROW_TO_WIDE) begin : g_pack
    logic [WW-1:0]    stage_q, stage_d;
    logic [SUB_W-1:0] stage_cnt_q;
    logic             last_slot;

    for (genvar gi = 0; gi < R; gi++) begin : g_slot
      localparam int LSB = (MSB_FIRST != 0) ? (R - 1 - gi) * NW : gi * NW;
      assign stage_d[LSB +: NW] = (wr_accept && stage_cnt_q == SUB_W'(gi)) ? wr_data
                                                                          : stage_q[LSB +: NW];
    end

    // The R-th write goes straight to memory with its slice merged in, so it is readable next cycle.
    assign last_slot  = stage_cnt_q == SUB_W'(R - 1);
    assign ram_we     = wr_accept & last_slot;
    assign ram_wdata  = stage_d;
    assign wr_ptr_adv = ram_we;
    assign rd_ptr_adv = rd_accept;
    assign rd_data    = ram_rdata;

    always_ff @(posedge clk) begin
      if (hold) begin
        stage_q     <= '0;
        stage_cnt_q <= '0;
      end else if (wr_accept) begin
        stage_q     <= stage_d;
        stage_cnt_q <= last_slot ? '0 : stage_cnt_q + SUB_W'(1);
      end
    end
  end else begin : g_unpack
    logic [SUB_W-1:0] sub_q, rd_sel_q;
    logic             last_sub;
    logic [NW-1:0]    slice [R];

    for (genvar gi = 0; gi < R; gi++) begin : g_slice
      localparam int LSB = (MSB_FIRST != 0) ? (R - 1 - gi) * NW : gi * NW;
      assign slice[gi] = ram_rdata[LSB +: NW];
    end

    // Every accepted read re-fetches the word at rd_ptr; rd_sel_q remembers which slice it served.
    assign last_sub   = sub_q == SUB_W'(R - 1);
    assign ram_we     = wr_accept;
    assign ram_wdata  = wr_data;
    assign wr_ptr_adv = wr_accept;
    assign rd_ptr_adv = rd_accept & last_sub;
    assign rd_data    = slice[rd_sel_q];

    always_ff @(posedge clk) begin
      if (hold) begin
        sub_q    <= '0;
        rd_sel_q <= '0;
      end else if (rd_accept) begin
        rd_sel_q <= sub_q;
        sub_q    <= last_sub ? '0 : sub_q + SUB_W'(1);
      end
    end
  end

  sync_width_fifo_ram #(
    .ADDR_W(DEPTH_WIDTH),
    .DATA_W(WW)
  ) u_ram (
    .clk    (clk),
    .clr_i  (hold),
    .we_i   (ram_we),
    .waddr_i(wr_ptr_q),
    .wdata_i(ram_wdata),
    .re_i   (rd_accept),
    .raddr_i(rd_ptr_q),
    .rdata_o(ram_rdata)
  );

endmodule

// File: tb/tb_sync_width_fifo.sv
// Bench for sync_width_fifo: a 16-to-8 instance and an 8-to-16 MSB-first instance, each checked
// against a byte-queue reference model every cycle plus explicit table and corner-case expectations.
module tb_sync_width_fifo;

  localparam int LW    = 6;
  localparam int W_CAP = 32;
  localparam int N_CAP = 32;

  logic clk;
  logic rst;

  logic          w_flush, w_wr_en, w_rd_en;
  logic [15:0]   w_wr_data;
  logic          w_full, w_af, w_empty, w_ae, w_ovf, w_unf;
  logic [7:0]    w_rd_data;
  logic [LW-1:0] w_wl, w_rl;

  logic          n_flush, n_wr_en, n_rd_en;
  logic [7:0]    n_wr_data;
  logic          n_full, n_af, n_empty, n_ae, n_ovf, n_unf;
  logic [15:0]   n_rd_data;
  logic [LW-1:0] n_wl, n_rl;

  int checks = 0;
  int passed = 0;
  int w_lvl  = 0;
  int n_lvl  = 0;
  logic [7:0] w_sb[$];
  logic [7:0] n_sb[$];

  typedef struct {
    logic        we;
    logic [15:0] wd;
    logic        re;
    logic        fl;
    int          exp_rl;
    logic        exp_empty;
    logic        exp_unf;
    logic        chk_rd;
    logic [7:0]  exp_rd;
  } vec_t;
  vec_t vecs[14];

  sync_width_fifo #(
    .WR_DATA_WIDTH(16), .RD_DATA_WIDTH(8), .DEPTH_WIDTH(4), .MSB_FIRST(0),
    .ALMOST_FULL_NUM(12), .ALMOST_EMPTY_NUM(4)
  ) dut_w (
    .clk(clk), .rst(rst), .flush(w_flush), .wr_en(w_wr_en), .wr_data(w_wr_data),
    .wr_full(w_full), .almost_full(w_af), .wr_water_level(w_wl), .rd_en(w_rd_en),
    .rd_data(w_rd_data), .rd_empty(w_empty), .almost_empty(w_ae), .rd_water_level(w_rl),
    .overflow(w_ovf), .underflow(w_unf)
  );

  sync_width_fifo #(
    .WR_DATA_WIDTH(8), .RD_DATA_WIDTH(16), .DEPTH_WIDTH(4), .MSB_FIRST(1),
    .ALMOST_FULL_NUM(30), .ALMOST_EMPTY_NUM(4)
  ) dut_n (
    .clk(clk), .rst(rst), .flush(n_flush), .wr_en(n_wr_en), .wr_data(n_wr_data),
    .wr_full(n_full), .almost_full(n_af), .wr_water_level(n_wl), .rd_en(n_rd_en),
    .rd_data(n_rd_data), .rd_empty(n_empty), .almost_empty(n_ae), .rd_water_level(n_rl),
    .overflow(n_ovf), .underflow(n_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic w_cycle(input logic we, input logic [15:0] wd, input logic re, input logic fl);
    logic wacc, racc, xovf, xunf;
    logic [7:0] xrd;
    w_wr_en = we; w_wr_data = wd; w_rd_en = re; w_flush = fl;
    wacc = we && !fl && (W_CAP - w_lvl >= 2);
    racc = re && !fl && (w_lvl >= 1);
    xovf = we && !fl && !wacc;
    xunf = re && !fl && !racc;
    @(posedge clk); #1;
    w_wr_en = 1'b0; w_rd_en = 1'b0; w_flush = 1'b0;
    if (fl) begin
      w_lvl = 0;
      w_sb.delete();
    end else begin
      if (racc) begin
        xrd = w_sb.pop_front();
        chk("w_rd_data", 32'(w_rd_data), 32'(xrd));
      end
      if (wacc) begin
        w_sb.push_back(wd[7:0]);
        w_sb.push_back(wd[15:8]);
      end
      w_lvl = w_lvl + (wacc ? 2 : 0) - (racc ? 1 : 0);
    end
    chk("w_overflow", 32'(w_ovf), 32'(xovf));
    chk("w_underflow", 32'(w_unf), 32'(xunf));
    chk("w_rd_level", 32'(w_rl), w_lvl);
    chk("w_wr_level", 32'(w_wl), w_lvl / 2);
    chk("w_rd_empty", 32'(w_empty), 32'(w_lvl < 1));
    chk("w_wr_full", 32'(w_full), 32'(w_lvl > W_CAP - 2));
    chk("w_almost_full", 32'(w_af), 32'(w_lvl / 2 >= 12));
    chk("w_almost_empty", 32'(w_ae), 32'(w_lvl <= 4));
  endtask

  task automatic n_cycle(input logic we, input logic [7:0] wd, input logic re, input logic fl);
    logic wacc, racc, xovf, xunf;
    logic [7:0] b0, b1;
    n_wr_en = we; n_wr_data = wd; n_rd_en = re; n_flush = fl;
    wacc = we && !fl && (N_CAP - n_lvl >= 1);
    racc = re && !fl && (n_lvl >= 2);
    xovf = we && !fl && !wacc;
    xunf = re && !fl && !racc;
    @(posedge clk); #1;
    n_wr_en = 1'b0; n_rd_en = 1'b0; n_flush = 1'b0;
    if (fl) begin
      n_lvl = 0;
      n_sb.delete();
    end else begin
      if (racc) begin
        b0 = n_sb.pop_front();
        b1 = n_sb.pop_front();
        chk("n_rd_data", 32'(n_rd_data), 32'({b0, b1}));
      end
      if (wacc) n_sb.push_back(wd);
      n_lvl = n_lvl + (wacc ? 1 : 0) - (racc ? 2 : 0);
    end
    chk("n_overflow", 32'(n_ovf), 32'(xovf));
    chk("n_underflow", 32'(n_unf), 32'(xunf));
    chk("n_rd_level", 32'(n_rl), n_lvl / 2);
    chk("n_wr_level", 32'(n_wl), n_lvl);
    chk("n_rd_empty", 32'(n_empty), 32'(n_lvl < 2));
    chk("n_wr_full", 32'(n_full), 32'(n_lvl >= N_CAP));
    chk("n_almost_full", 32'(n_af), 32'(n_lvl >= 30));
    chk("n_almost_empty", 32'(n_ae), 32'(n_lvl / 2 <= 4));
  endtask

  initial begin
    vecs[0]  = '{1'b1, 16'hA1B2, 1'b0, 1'b0, 2,  1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b1, 8'hB2};
    vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 0,  1'b1, 1'b0, 1'b1, 8'hA1};
    vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 0,  1'b1, 1'b1, 1'b1, 8'hA1};
    vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 0,  1'b1, 1'b0, 1'b1, 8'hA1};
    vecs[5]  = '{1'b1, 16'h0102, 1'b0, 1'b0, 2,  1'b0, 1'b0, 1'b0, 8'h00};
    vecs[6]  = '{1'b1, 16'h0304, 1'b0, 1'b0, 4,  1'b0, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{1'b1, 16'h0506, 1'b0, 1'b0, 6,  1'b0, 1'b0, 1'b0, 8'h00};
    vecs[8]  = '{1'b1, 16'h0708, 1'b0, 1'b0, 8,  1'b0, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{1'b1, 16'h090A, 1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{1'b1, 16'h5555, 1'b0, 1'b1, 0,  1'b1, 1'b0, 1'b1, 8'h00};
    vecs[11] = '{1'b1, 16'hBEEF, 1'b0, 1'b0, 2,  1'b0, 1'b0, 1'b0, 8'h00};
    vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b1, 8'hEF};
    vecs[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0,  1'b1, 1'b0, 1'b1, 8'hBE};

    w_flush = 1'b0; w_wr_en = 1'b0; w_rd_en = 1'b0; w_wr_data = '0;
    n_flush = 1'b0; n_wr_en = 1'b0; n_rd_en = 1'b0; n_wr_data = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_w_rd_data", 32'(w_rd_data), 0);
    chk("rst_w_empty", 32'(w_empty), 1);
    chk("rst_w_full", 32'(w_full), 0);
    chk("rst_w_almost_full", 32'(w_af), 0);
    chk("rst_w_almost_empty", 32'(w_ae), 1);
    chk("rst_w_levels", 32'({w_wl, w_rl}), 0);
    chk("rst_w_pulses", 32'({w_ovf, w_unf}), 0);
    chk("rst_n_rd_data", 32'(n_rd_data), 0);
    chk("rst_n_empty", 32'(n_empty), 1);
    chk("rst_n_levels", 32'({n_wl, n_rl}), 0);
    rst = 1'b0;

    // Table: 0xA1B2 unpack order, empty read, flush with a concurrent write, recovery
    for (int i = 0; i < 14; i++) begin
      w_cycle(vecs[i].we, vecs[i].wd, vecs[i].re, vecs[i].fl);
      chk($sformatf("vec%0d_rd_level", i), 32'(w_rl), vecs[i].exp_rl);
      chk($sformatf("vec%0d_rd_empty", i), 32'(w_empty), 32'(vecs[i].exp_empty));
      chk($sformatf("vec%0d_underflow", i), 32'(w_unf), 32'(vecs[i].exp_unf));
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rd_data", i), 32'(w_rd_data), 32'(vecs[i].exp_rd));
    end

    // 17 back-to-back writes into a 16-word FIFO
    for (int i = 1; i <= 17; i++) begin
      w_cycle(1'b1, 16'(16'h1000 + i * 16'h0111), 1'b0, 1'b0);
      if (i == 11) chk("fill_af_before_12", 32'(w_af), 0);
      if (i == 12) chk("fill_af_at_12", 32'(w_af), 1);
      if (i == 15) chk("fill_full_before_16", 32'(w_full), 0);
      if (i == 16) chk("fill_full_at_16", 32'(w_full), 1);
      if (i == 17) begin
        chk("fill_ovf_17", 32'(w_ovf), 1);
        chk("fill_wr_level_17", 32'(w_wl), 16);
        chk("fill_rd_level_17", 32'(w_rl), 32);
      end
    end
    w_cycle(1'b1, 16'hDEAD, 1'b1, 1'b0);
    chk("full_rw_ovf", 32'(w_ovf), 1);
    chk("full_rw_rd_level", 32'(w_rl), 31);
    for (int i = 0; i < 31; i++) w_cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    w_cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("drain_underflow", 32'(w_unf), 1);

    repeat (150) w_cycle(1'($urandom_range(0, 2) != 0), 16'($urandom), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 39) == 0));

    // Narrow-to-wide, MSB first
    n_cycle(1'b1, 8'h11, 1'b0, 1'b0);
    chk("pack_empty_after_1", 32'(n_empty), 1);
    n_cycle(1'b1, 8'h22, 1'b0, 1'b0);
    chk("pack_empty_after_2", 32'(n_empty), 0);
    n_cycle(1'b1, 8'h33, 1'b0, 1'b0);
    n_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pack_rd_data", 32'(n_rd_data), 32'h1122);
    chk("pack_rd_level", 32'(n_rl), 0);
    chk("pack_wr_level", 32'(n_wl), 1);
    n_cycle(1'b1, 8'h44, 1'b0, 1'b0);
    n_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pack_rd_data2", 32'(n_rd_data), 32'h3344);
    for (int i = 0; i < 33; i++) n_cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    chk("pack_ovf", 32'(n_ovf), 1);
    n_cycle(1'b1, 8'hEE, 1'b1, 1'b0);
    chk("pack_full_rw_ovf", 32'(n_ovf), 1);
    chk("pack_full_rw_wr_level", 32'(n_wl), 30);

    repeat (150) n_cycle(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 39) == 0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
